// File: rtl/eqz_mult_ctrl.sv
// eqz_mult_ctrl: sequencer for the repeated-addition multiplier datapath.
// Handles the start/done handshake, abort, and an iteration watchdog.
module eqz_mult_ctrl #(
   parameter int MAX_ITER = 255,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             data_valid,
   input  logic             eqz,
   output logic             ld_a,
   output logic             ld_b,
   output logic             clr_p,
   output logic             ld_p,
   output logic             dec_b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] iter_cnt
);
   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CHECK, ADD, DONE, ERR} state_t;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
   logic             err_q, err_d;
   always_comb begin
      state_d    = state_q;
      iter_cnt_d = iter_cnt_q;
      err_d      = err_q;
      case (state_q)
         IDLE: if (start) begin
            state_d    = LOAD_A;
            iter_cnt_d = '0;
            err_d      = 1'b0;
         end
         LOAD_A:  if (data_valid) state_d = LOAD_B;
         LOAD_B:  if (data_valid) state_d = CHECK;
         CHECK:   state_d = eqz ? DONE : (iter_cnt_q == MAX_CNT) ? ERR : ADD;
         // ADD strobes reach the datapath even when aborted, so the count follows them.
         ADD: begin
            state_d    = CHECK;
            iter_cnt_d = iter_cnt_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         ERR: begin
            state_d = IDLE;
            err_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         err_d   = err_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         iter_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_cnt_q <= iter_cnt_d;
         err_q      <= err_d;
      end
   end
   assign ld_a     = state_q == LOAD_A && data_valid;
   assign ld_b     = state_q == LOAD_B && data_valid;
   assign clr_p    = state_q == LOAD_B && data_valid;
   assign ld_p     = state_q == ADD;
   assign dec_b    = state_q == ADD;
   assign busy     = state_q != IDLE;
   assign done     = state_q == DONE;
   assign err      = err_q;
   assign iter_cnt = iter_cnt_q;
endmodule

// File: doc/eqz_mult_ctrl.md
Name: eqz_mult_ctrl

Overview:
- Control sequencer for the repeated-addition multiplier datapath built around the equal-to-zero detector.
- The datapath holds operand register A, down-counter B, product accumulator P, and produces eqz (B == 0).
- This block runs the full sequence: operand load, clear, add/decrement loop until eqz, completion.
- Adds a start/done handshake, abort, and an iteration watchdog. Sits between the system bus-side requester and the datapath.

Parameters:
- MAX_ITER, 255: maximum add/decrement iterations before the watchdog flags an error.
- CNT_W, 8: width of the iteration counter. Must hold MAX_ITER.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  cancel the current operation; ignored in IDLE.
- data_valid  input  1  operand present on the datapath input bus this cycle.
- eqz  input  1  from datapath: counter B equals zero.
- ld_a  output  1  load operand A (combinational: state==LOAD_A && data_valid).
- ld_b  output  1  load counter B (combinational: state==LOAD_B && data_valid).
- clr_p  output  1  clear accumulator P (combinational: state==LOAD_B && data_valid).
- ld_p  output  1  P <= P + A (asserted in ADD).
- dec_b  output  1  B <= B - 1 (asserted in ADD).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse (state DONE).
- err  output  1  sticky watchdog error.
- iter_cnt  output  CNT_W  iterations performed in the current operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, iter_cnt=0, err=0. All outputs are 0 while in reset.
- States: IDLE, LOAD_A, LOAD_B, CHECK, ADD, DONE, ERR. Registered state; outputs decoded from state (plus data_valid for ld_a/ld_b/clr_p).
- IDLE:
  - start=1 -> LOAD_A.
  - On that same edge: iter_cnt <= 0 and err <= 0.
- LOAD_A: waits indefinitely for data_valid. data_valid=1 -> ld_a pulses; next state LOAD_B.
- LOAD_B: waits for data_valid. data_valid=1 -> ld_b and clr_p pulse together; next state CHECK.
- CHECK (eqz is valid here, one cycle after the datapath update):
  - eqz=1 -> DONE.
  - eqz=0 and iter_cnt==MAX_ITER -> ERR.
  - Otherwise -> ADD.
- ADD:
  - ld_p=1 and dec_b=1 for exactly one cycle; iter_cnt <= iter_cnt+1.
  - Next state CHECK. An ADD is never issued without a preceding CHECK.
- DONE: done=1 for one cycle -> IDLE. iter_cnt holds its final value until the next start.
- ERR: err <= 1 (sticky until next accepted start) -> IDLE next cycle. done is not asserted.
- abort=1 in any non-IDLE state: next state IDLE, no done, err unchanged, iter_cnt holds. abort has priority over all other transitions, including data_valid and eqz.
- start while busy is ignored (no queuing).
- start and abort both high in IDLE: start is accepted.
- Latency with data_valid held high, B operand = n ≤ MAX_ITER:
  - start sampled at edge 0.
  - done is high in cycle 4+2n after that edge.
  - busy is high from cycle 1 through cycle 4+2n.
- B operand = 0: no ADD is issued. done at cycle 4, iter_cnt=0.
- Reset asserted mid-operation returns to IDLE immediately; the datapath contents are don't-care.
- ld_p/dec_b never assert outside ADD. ld_a/ld_b/clr_p never assert outside their load states.

Test Plan:
- Reset while in ADD (rst_n low mid-loop) -> state IDLE asynchronously; busy=0, err=0, iter_cnt=0, all strobes 0.
- start, data_valid high, A=5, B=3, datapath model responds -> 3 ADD cycles; done at cycle 10; product 15; iter_cnt=3; ld_p/dec_b each pulsed exactly 3 times.
- B=0 -> no ld_p; done at cycle 4; iter_cnt=0; P=0 via clr_p.
- MAX_ITER=4 with eqz forced 0 -> 4 ADDs, then ERR; err=1, no done. A following start clears err.
- data_valid withheld 5 cycles in LOAD_A then in LOAD_B -> FSM stalls with no strobes. Loads happen on the valid cycles and latency extends by 10.
- abort during the third ADD with B=6 -> next cycle IDLE, busy=0, no done, iter_cnt=3. A start pulse asserted during busy is ignored.
